sipo_frame_controller: RTL and testbench
========================================

SIPO_FRAME_CONTROLLER -- requirements
Module: sipo_frame_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32: word width in bits, legal range 2..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  begin reception; clears any partial word and latches dir.
REQ-005 SHALL have port stop  input  1  end reception; discards any partial word.
REQ-006 SHALL have port dir  input  1  shift direction, 1 = MSB-first (shift left, new bit into LSB), 0 = LSB-first (shift right, new bit into MSB).
REQ-007 SHALL have port data_in  input  1  serial bit.
REQ-008 SHALL have port bit_valid  input  1  data_in is sampled on this cycle.
REQ-009 SHALL have port out_data  output  WIDTH  last completed word.
REQ-010 SHALL have port out_valid  output  1  out_data holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out_data.
REQ-012 SHALL have port busy  output  1  controller is in SHIFT.
REQ-013 SHALL have port bit_cnt  output  $clog2(WIDTH)  bits accepted into the current word.
REQ-014 SHALL have port overrun  output  1  sticky: a completed word was dropped.
REQ-015 SHALL have port clear_err  input  1  clears overrun.

Function
REQ-016 SHALL implement FSM states IDLE and SHIFT; busy = (state == SHIFT).
REQ-017 In IDLE, bit_valid SHALL be ignored; start SHALL move to SHIFT with shift register = 0, bit_cnt = 0, and dir latched.
REQ-018 In SHIFT, each bit_valid=1 cycle SHALL shift data_in in using the latched dir and increment bit_cnt; gaps in bit_valid SHALL hold all state.
REQ-019 A dir change after start SHALL have no effect until the next start.
REQ-020 On the edge that samples the WIDTH-th bit, out_data SHALL load the full word including that bit, out_valid SHALL be 1 the following cycle, bit_cnt and shift register SHALL clear, and state SHALL stay SHIFT (continuous reception).
REQ-021 Handshake: transfer when out_valid & out_ready; out_valid SHALL clear the next cycle unless a word completes on the same edge, in which case out_valid stays 1 with the new word and overrun is not set.
REQ-022 out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 If a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, out_data SHALL keep the old word, and overrun SHALL be set.
REQ-024 clear_err SHALL clear overrun; a same-cycle overrun event SHALL win, leaving overrun at 1.
REQ-025 stop SHALL move to IDLE and clear bit_cnt and the shift register; a bit_valid on the same cycle SHALL be discarded; pending out_valid/out_data SHALL be unaffected.
REQ-026 start while in SHIFT SHALL restart the word: partial bits are discarded and dir is re-latched; a same-cycle bit_valid SHALL be discarded.
REQ-027 stop SHALL take priority over start on the same cycle.

Reset
REQ-028 rst=1 SHALL immediately, without a clock edge, force state IDLE, out_data 0, out_valid 0, busy 0, bit_cnt 0, overrun 0, shift register 0, and latched dir 1.
REQ-029 A reset mid-word SHALL discard the partial word; no output SHALL reflect it after release.

Structure
REQ-030 A shared package sipo_pkg SHALL hold the FSM state encodings and the default WIDTH constant.
REQ-031 The shift datapath SHALL be one sub-module, sipo_shift_core (ports: clk, rst, en, clr, dir, data_in, word), reset asynchronously; the FSM, counter, and handshake SHALL live in the top level.

Verification (WIDTH=8)
REQ-032 dir=1, start, bits 1,0,1,1,0,0,1,0 on consecutive bit_valid cycles, out_ready=1 -> out_valid high the cycle after the 8th bit, out_data=8'hB2, overrun=0.
REQ-033 Same bits with dir=0 -> out_data=8'h4D; toggling dir mid-word does not change the result.
REQ-034 out_ready=0, words 8'hFF then 8'h00 -> out_data stays 8'hFF, overrun=1; clear_err pulse -> overrun=0; out_ready -> out_valid drops next cycle.
REQ-035 Stop after 5 bits -> busy=0, bit_cnt=0, out_valid stays 0; a fresh start plus 8 bits -> correct word.
REQ-036 bit_valid with random idle gaps -> same word as the gapless case; bit_cnt holds during gaps.
REQ-037 rst asserted between clock edges after 4 bits -> all outputs 0 before the next edge; after release, start plus 8 bits -> correct word.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out frame controller:
// FSM state encoding and the default word width.
package sipo_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register datapath: clear wins over enable; dir=1 shifts left (new bit
// into LSB), dir=0 shifts right (new bit into MSB).
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             dir,
  input  logic             data_in,
  output logic [WIDTH-1:0] word
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word <= '0;
    end else if (clr) begin
      word <= '0;
    end else if (en) begin
      word <= dir ? {word[WIDTH-2:0], data_in} : {data_in, word[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/sipo_frame_controller.sv
// Serial-to-parallel frame controller: IDLE/SHIFT FSM, bit counter and a
// valid/ready output register with sticky overrun on dropped words.
module sipo_frame_controller
  import sipo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     dir,
  input  logic                     data_in,
  input  logic                     bit_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun,
  input  logic                     clear_err
);

  localparam int CW = $clog2(WIDTH);

  // Output handshake: a word moves when out_valid & out_ready on a rising
  // edge; out_data is held while out_valid=1 and out_ready=0.

  state_t           state, state_nxt;
  logic             dir_q;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] full_word;
  logic             restart;
  logic             take_bit;
  logic             word_done;
  logic             accept_word;

  assign busy     = (state == SHIFT);
  assign restart  = start & ~stop;
  // start/stop on the same cycle as bit_valid discard the bit.
  assign take_bit = busy & bit_valid & ~stop & ~start;
  assign word_done = take_bit & (bit_cnt == CW'(WIDTH - 1));
  // The completing bit is folded in here; the core itself is cleared.
  assign full_word = dir_q ? {word[WIDTH-2:0], data_in} : {data_in, word[WIDTH-1:1]};
  assign accept_word = word_done & (~out_valid | out_ready);

  sipo_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .en      (take_bit & ~word_done),
    .clr     (stop | start | word_done),
    .dir     (dir_q),
    .data_in (data_in),
    .word    (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (restart) state_nxt = SHIFT;
      SHIFT:   if (stop)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt <= '0;
      dir_q   <= 1'b1;
    end else begin
      if (stop | start | word_done) begin
        bit_cnt <= '0;
      end else if (take_bit) begin
        bit_cnt <= bit_cnt + CW'(1);
      end
      if (restart) begin
        dir_q <= dir;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept_word) begin
        out_data  <= full_word;
        out_valid <= 1'b1;
      end else if (out_valid & out_ready) begin
        out_valid <= 1'b0;
      end
      // A drop on the same edge as clear_err leaves overrun set.
      if (word_done & ~accept_word) begin
        overrun <= 1'b1;
      end else if (clear_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Directed bench for sipo_frame_controller at WIDTH=8 with hand-computed words.
module tb_sipo_frame_controller;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             dir = 1'b1;
  logic             data_in = 1'b0;
  logic             bit_valid = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             busy;
  logic [2:0]       bit_cnt;
  logic             overrun;
  logic             clear_err = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  sipo_frame_controller #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .data_in   (data_in),
    .bit_valid (bit_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun),
    .clear_err (clear_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow at the same point.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic d);
    dir = d;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic drive_bit(input logic b);
    bit_valid = 1'b1;
    data_in = b;
    cyc();
    bit_valid = 1'b0;
  endtask

  // seq[7] goes first. max_gap adds idle cycles before each bit; the last bit
  // is driven with out_ready/clear_err set to last_ready/last_clear.
  task automatic send_word(input logic [7:0] seq, input int max_gap, input logic toggle,
                           input logic last_ready, input logic last_clear);
    for (int i = 7; i >= 0; i--) begin
      int gap;
      gap = (max_gap > 0) ? $urandom_range(1, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        cyc();
        chk("gap_bit_cnt", bit_cnt, 64'(7 - i));
      end
      if (toggle) dir = ~dir;
      if (i == 0) begin
        out_ready = last_ready;
        clear_err = last_clear;
      end
      drive_bit(seq[i]);
      clear_err = 1'b0;
    end
  endtask

  initial begin
    // Reset applies without any clock edge.
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_overrun", overrun, 0);
    #2 rst = 1'b0;
    cyc();

    // bit_valid ignored in IDLE
    drive_bit(1'b1);
    chk("idle_ignore_cnt", bit_cnt, 0);
    chk("idle_busy", busy, 0);

    // MSB-first word
    pulse_start(1'b1);
    chk("start_busy", busy, 1);
    send_word(8'hB2, 0, 1'b0, 1'b1, 1'b0);
    chk("msb_valid", out_valid, 1);
    chk("msb_data", out_data, 8'hB2);
    chk("msb_overrun", overrun, 0);
    chk("msb_cnt_wrap", bit_cnt, 0);
    chk("msb_still_busy", busy, 1);
    cyc();
    chk("msb_consumed", out_valid, 0);

    // LSB-first, toggling dir input every bit
    pulse_start(1'b0);
    send_word(8'hB2, 0, 1'b1, 1'b1, 1'b0);
    chk("lsb_data", out_data, 8'h4D);
    chk("lsb_valid", out_valid, 1);
    cyc();
    chk("lsb_consumed", out_valid, 0);

    // Overrun: FF then 00 with consumer stalled
    out_ready = 1'b0;
    pulse_start(1'b1);
    send_word(8'hFF, 0, 1'b0, 1'b0, 1'b0);
    chk("ovr_first_valid", out_valid, 1);
    chk("ovr_first_data", out_data, 8'hFF);
    send_word(8'h00, 0, 1'b0, 1'b0, 1'b0);
    chk("ovr_keep_data", out_data, 8'hFF);
    chk("ovr_set", overrun, 1);
    chk("ovr_still_valid", out_valid, 1);
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    chk("ovr_cleared", overrun, 0);
    // Drop on the same edge as clear_err: overrun wins
    send_word(8'h3C, 0, 1'b0, 1'b0, 1'b1);
    chk("ovr_vs_clear", overrun, 1);
    chk("ovr_vs_clear_data", out_data, 8'hFF);
    clear_err = 1'b1;
    cyc();
    clear_err = 1'b0;
    chk("ovr_cleared2", overrun, 0);
    // Consume and complete on the same edge: new word, no overrun
    send_word(8'h5A, 0, 1'b0, 1'b1, 1'b0);
    chk("same_edge_valid", out_valid, 1);
    chk("same_edge_data", out_data, 8'h5A);
    chk("same_edge_overrun", overrun, 0);
    cyc();
    chk("same_edge_consumed", out_valid, 0);

    // Stop after 5 bits, with a bit_valid on the stop cycle
    pulse_start(1'b1);
    for (int i = 0; i < 5; i++) drive_bit(1'b1);
    chk("pre_stop_cnt", bit_cnt, 5);
    stop = 1'b1;
    drive_bit(1'b1);
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_cnt", bit_cnt, 0);
    chk("stop_no_valid", out_valid, 0);
    chk("stop_data_kept", out_data, 8'h5A);
    // stop beats start
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("stop_over_start", busy, 0);
    pulse_start(1'b1);
    send_word(8'hC3, 0, 1'b0, 1'b1, 1'b0);
    chk("after_stop_data", out_data, 8'hC3);
    chk("after_stop_valid", out_valid, 1);

    // Restart mid-word with a same-cycle bit_valid
    pulse_start(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    start = 1'b1;
    dir = 1'b1;
    drive_bit(1'b1);
    start = 1'b0;
    chk("restart_cnt", bit_cnt, 0);
    chk("restart_busy", busy, 1);
    send_word(8'h96, 0, 1'b0, 1'b1, 1'b0);
    chk("restart_data", out_data, 8'h96);

    // Random gaps between bits
    pulse_start(1'b1);
    send_word(8'hB2, 3, 1'b0, 1'b1, 1'b0);
    chk("gap_data", out_data, 8'hB2);
    chk("gap_valid", out_valid, 1);
    cyc();

    // Asynchronous reset mid-word
    pulse_start(1'b1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_data", out_data, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_bit_cnt", bit_cnt, 0);
    chk("arst_overrun", overrun, 0);
    #2 rst = 1'b0;
    cyc();
    pulse_start(1'b1);
    chk("arst_restart_cnt", bit_cnt, 0);
    send_word(8'hE7, 0, 1'b0, 1'b1, 1'b0);
    chk("arst_word", out_data, 8'hE7);
    chk("arst_word_valid", out_valid, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
